// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame geometry defaults and the receiver state encoding
// (also used by the transmitter side of the UART).
package uart_rx_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Bus-side view of the UART receiver: FIFO pop/head, status flags and baud request.
// The receiver drives everything except rd_en; the bus master pops with rd_en.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);

  logic                 rd_en;
  logic [DATA_BITS-1:0] data;
  logic                 RX_FIFO_EMPTY;
  logic                 RX_FIFO_FULL;
  logic                 frame_err;
  logic                 overrun;
  logic                 bps_en;

  modport master (
    output rd_en,
    input  data, RX_FIFO_EMPTY, RX_FIFO_FULL, frame_err, overrun, bps_en
  );

  modport slave (
    input  rd_en,
    output data, RX_FIFO_EMPTY, RX_FIFO_FULL, frame_err, overrun, bps_en
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO: q always shows the head entry.
// A write into a full FIFO only lands when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign q     = mem_q[rd_ptr_q];

  // Pop on empty is dropped, so a simultaneous write into an empty FIFO simply wins.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || rd_en);

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RXD, finds mid-cell sample points with the oversample
// tick, checks the stop bit and buffers good bytes in a FWFT receive FIFO.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      RST,
  input  logic      clk_uart16,
  input  logic      RXD,
  uart_rx_if.slave  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxd_s;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 wr_q, wr_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_q;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RXD};
    end
  end

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    wr_d        = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = wr_q && fifo_full && !bus.rd_en;
    case (state_q)
      RX_IDLE: begin
        if (!rxd_s) begin
          state_d = RX_START;
          tcnt_d  = '0;
        end
      end
      RX_START: begin
        if (clk_uart16) begin
          if (tcnt_q == T_HALF) begin
            // A start bit that is high again at mid-cell was a glitch: drop silently.
            if (!rxd_s) begin
              state_d = RX_DATA;
              tcnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (clk_uart16) begin
          if (tcnt_q == T_FULL) begin
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            tcnt_d  = '0;
            if (bcnt_q == B_LAST) begin
              state_d = RX_STOP;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (clk_uart16) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d = '0;
            if (rxd_s) begin
              wr_d    = 1'b1;
              state_d = RX_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = RX_WAIT_HI;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      RX_WAIT_HI: begin
        // A held-low line (break) must return high before a new start is accepted.
        if (rxd_s) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= RX_IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      wr_q        <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      wr_q        <= wr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .RST   (RST),
    .wr_en (wr_q),
    .din   (shift_q),
    .rd_en (bus.rd_en),
    .q     (fifo_q),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.data          = fifo_q;
  assign bus.RX_FIFO_EMPTY = fifo_empty;
  assign bus.RX_FIFO_FULL  = fifo_full;
  assign bus.frame_err     = frame_err_q;
  assign bus.overrun       = overrun_q;
  assign bus.bps_en        = (state_q != RX_IDLE);

endmodule
